// File: rtl/autoconfig_ram_ctrl.sv
// AutoConfig (Zorro II) responder plus a 2 MB FastRAM window decoder for a 68000 bus.
// The board answers the E8xxxx configuration space while unconfigured, then either
// takes a base address (and becomes a FastRAM window) or is told to shut up.
//
// Ports:
//   CPU_CLK            sole clock, rising edge
//   RESET              asynchronous, active-high reset
//   CPU_AS_n, RW       68000 address strobe and read/write (1 = read)
//   UDS_n, LDS_n       68000 data strobes
//   ADDRESS[23:1]      CPU address
//   DATA_IN[3:0]       CPU DATA[15:12] for configuration writes
//   CFGIN_n            AutoConfig chain enable (low = may respond)
//   DATA_OUT[3:0]      configuration nibble for DATA[15:12]
//   DATA_OE            drive enable for DATA_OUT
//   DTACK_n            acknowledge for cycles this board decodes
//   RAM_CS_n[1:0]      {upper, lower} FastRAM byte selects
//   CFGOUT_n           low once configured or shut up
module autoconfig_ram_ctrl #(
  parameter logic [7:0]  PRODUCT_ID   = 8'h01,
  parameter logic [15:0] MANUFACTURER = 16'h07DB,
  parameter logic [31:0] SERIAL       = 32'h00000000,
  parameter int unsigned RAM_WAIT     = 0
) (
  input  logic        CPU_CLK,
  input  logic        RESET,
  input  logic        CPU_AS_n,
  input  logic        RW,
  input  logic        UDS_n,
  input  logic        LDS_n,
  input  logic [23:1] ADDRESS,
  input  logic [3:0]  DATA_IN,
  input  logic        CFGIN_n,
  output logic [3:0]  DATA_OUT,
  output logic        DATA_OE,
  output logic        DTACK_n,
  output logic [1:0]  RAM_CS_n,
  output logic        CFGOUT_n
);

  typedef enum logic [1:0] {CfgUnconf, CfgConfigured, CfgShutup} cfg_e;
  typedef enum logic [1:0] {CycIdle, CycAccess, CycAck} cyc_e;

  localparam logic [1:0] RamWait = 2'(RAM_WAIT);

  cfg_e        cfg_q, cfg_d;
  cyc_e        cyc_q, cyc_d;
  logic [7:0]  base_q, base_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        ram_q, ram_d;   // current cycle is FastRAM (else AutoConfig)
  logic        rw_q, rw_d;
  logic [3:0]  dout_q, dout_d;
  logic [1:0]  cs_q, cs_d;
  logic        ac_match, ram_match;

  // Only base[7:5] select the 2 MB window; the low bits are held but never decoded.
  logic unused_base;
  assign unused_base = ^base_q[4:0];

  // Configuration ROM nibble for a word address; offsets outside page 0 read as F.
  function automatic logic [3:0] ac_nibble(input logic [14:0] word);
    logic [3:0] nib;
    nib = 4'hF;
    if (word[14:7] == 8'h00) begin
      case (word[6:0])
        7'd0:    nib = 4'hE;
        7'd1:    nib = 4'h6;
        7'd2:    nib = ~PRODUCT_ID[7:4];
        7'd3:    nib = ~PRODUCT_ID[3:0];
        7'd4:    nib = ~4'h8;
        7'd8:    nib = ~MANUFACTURER[15:12];
        7'd9:    nib = ~MANUFACTURER[11:8];
        7'd10:   nib = ~MANUFACTURER[7:4];
        7'd11:   nib = ~MANUFACTURER[3:0];
        7'd12:   nib = ~SERIAL[31:28];
        7'd13:   nib = ~SERIAL[27:24];
        7'd14:   nib = ~SERIAL[23:20];
        7'd15:   nib = ~SERIAL[19:16];
        7'd16:   nib = ~SERIAL[15:12];
        7'd17:   nib = ~SERIAL[11:8];
        7'd18:   nib = ~SERIAL[7:4];
        7'd19:   nib = ~SERIAL[3:0];
        default: nib = 4'hF;  // flags low byte, reserved and unused offsets
      endcase
    end
    return nib;
  endfunction

  always_comb begin
    ac_match  = (ADDRESS[23:16] == 8'hE8) && !CFGIN_n && (cfg_q == CfgUnconf);
    ram_match = (cfg_q == CfgConfigured) && (ADDRESS[23:21] == base_q[7:5]);

    cyc_d  = cyc_q;
    cfg_d  = cfg_q;
    base_d = base_q;
    cnt_d  = cnt_q;
    ram_d  = ram_q;
    rw_d   = rw_q;
    dout_d = dout_q;

    unique case (cyc_q)
      CycIdle: begin
        if (!CPU_AS_n && (ac_match || ram_match)) begin
          cyc_d  = CycAccess;
          ram_d  = ram_match;
          rw_d   = RW;
          cnt_d  = ram_match ? RamWait : 2'd0;
          dout_d = (ac_match && RW) ? ac_nibble(ADDRESS[15:1]) : 4'hF;
        end
      end
      CycAccess: begin
        if (CPU_AS_n) begin
          cyc_d = CycIdle;  // abort: no acknowledge, no register write
        end else if (cnt_q == 2'd0) begin
          cyc_d = CycAck;
          if (!ram_q && !rw_q) begin
            case (ADDRESS[15:1])
              15'h0025: base_d[3:0] = DATA_IN;  // byte offset 4A
              15'h0024: begin                   // byte offset 48
                base_d[7:4] = DATA_IN;
                cfg_d       = CfgConfigured;
              end
              15'h0026: cfg_d = CfgShutup;      // byte offset 4C
              default: ;
            endcase
          end
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      CycAck: begin
        if (CPU_AS_n) cyc_d = CycIdle;
      end
      default: cyc_d = CycIdle;
    endcase

    cs_d = ((cyc_d != CycIdle) && ram_d) ? {UDS_n, LDS_n} : 2'b11;
  end

  always_ff @(posedge CPU_CLK or posedge RESET) begin
    if (RESET) begin
      cyc_q  <= CycIdle;
      cfg_q  <= CfgUnconf;
      base_q <= 8'h00;
      cnt_q  <= 2'd0;
      ram_q  <= 1'b0;
      rw_q   <= 1'b1;
      dout_q <= 4'hF;
      cs_q   <= 2'b11;
    end else begin
      cyc_q  <= cyc_d;
      cfg_q  <= cfg_d;
      base_q <= base_d;
      cnt_q  <= cnt_d;
      ram_q  <= ram_d;
      rw_q   <= rw_d;
      dout_q <= dout_d;
      cs_q   <= cs_d;
    end
  end

  assign DATA_OUT = dout_q;
  assign DATA_OE  = (cyc_q != CycIdle) && !ram_q && rw_q;
  assign DTACK_n  = (cyc_q != CycAck);
  assign RAM_CS_n = cs_q;
  assign CFGOUT_n = (cfg_q == CfgUnconf);

endmodule

// File: tb/tb_autoconfig_ram_ctrl.sv
// Randomized bench for autoconfig_ram_ctrl. A driver issues 68000 bus cycles and pushes
// the expected acknowledge into a queue; a monitor pops and compares on each DTACK.
module tb_autoconfig_ram_ctrl;
  localparam logic [7:0]  PID      = 8'h5A;
  localparam logic [15:0] MANUF    = 16'h07DB;
  localparam logic [31:0] SER      = 32'h1234ABCD;
  localparam int unsigned RAM_WAIT = 2;

  logic        CPU_CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        CPU_AS_n = 1'b1;
  logic        RW = 1'b1;
  logic        UDS_n = 1'b1;
  logic        LDS_n = 1'b1;
  logic [23:1] ADDRESS = '0;
  logic [3:0]  DATA_IN = '0;
  logic        CFGIN_n = 1'b0;
  logic [3:0]  DATA_OUT;
  logic        DATA_OE;
  logic        DTACK_n;
  logic [1:0]  RAM_CS_n;
  logic        CFGOUT_n;

  autoconfig_ram_ctrl #(
    .PRODUCT_ID(PID), .MANUFACTURER(MANUF), .SERIAL(SER), .RAM_WAIT(RAM_WAIT)
  ) dut (
    .CPU_CLK(CPU_CLK), .RESET(RESET), .CPU_AS_n(CPU_AS_n), .RW(RW), .UDS_n(UDS_n),
    .LDS_n(LDS_n), .ADDRESS(ADDRESS), .DATA_IN(DATA_IN), .CFGIN_n(CFGIN_n),
    .DATA_OUT(DATA_OUT), .DATA_OE(DATA_OE), .DTACK_n(DTACK_n), .RAM_CS_n(RAM_CS_n),
    .CFGOUT_n(CFGOUT_n)
  );

  initial forever #5 CPU_CLK = ~CPU_CLK;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;
  initial forever begin
    @(posedge CPU_CLK);
    edge_cnt++;
  end

  typedef struct {
    int         start;
    int         lat;
    bit         oe;
    logic [3:0] dout;
    logic [1:0] cs;
  } exp_t;
  exp_t expq[$];

  // Reference model: configuration state (0 unconf, 1 configured, 2 shut up), base, ROM.
  int         m_st = 0;
  logic [7:0] m_base = 8'h00;
  logic [3:0] rom[128];

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [3:0] nib(input logic [23:0] a);
    if (a[15:8] != 8'h00) return 4'hF;
    return rom[a[7:1]];
  endfunction

  task automatic check_reset_outputs();
    check("rst_dtack", int'(DTACK_n), 1);
    check("rst_oe", int'(DATA_OE), 0);
    check("rst_dout", int'(DATA_OUT), 'hF);
    check("rst_cs", int'(RAM_CS_n), 3);
    check("rst_cfgout", int'(CFGOUT_n), 1);
  endtask

  task automatic do_reset();
    @(negedge CPU_CLK);
    RESET = 1'b1;
    CPU_AS_n = 1'b1;
    #1 check_reset_outputs();
    @(negedge CPU_CLK);
    RESET = 1'b0;
    m_st = 0;
    m_base = 8'h00;
  endtask

  // One bus cycle. abort_edges > 0 negates AS after that many edges; rst_in_ack pulses
  // RESET once DTACK is seen.
  task automatic bus(input logic [23:0] a, input bit rw, input logic [1:0] ds,
                     input logic [3:0] din, input int abort_edges, input bit rst_in_ack);
    bit ac, ram, resp, got;
    int lows, sels;
    exp_t e;
    ac   = (a[23:16] == 8'hE8) && !CFGIN_n && (m_st == 0);
    ram  = (m_st == 1) && (a[23:21] == m_base[7:5]);
    resp = ac || ram;
    @(negedge CPU_CLK);
    ADDRESS = a[23:1];
    RW = rw;
    {UDS_n, LDS_n} = ds;
    DATA_IN = din;
    CPU_AS_n = 1'b0;
    if (resp && abort_edges == 0) begin
      e.start = edge_cnt;
      e.lat   = ram ? 2 + RAM_WAIT : 2;
      e.oe    = ac && rw;
      e.dout  = nib(a);
      e.cs    = ram ? ds : 2'b11;
      expq.push_back(e);
    end
    if (abort_edges > 0 || !resp) begin
      lows = 0;
      sels = 0;
      repeat ((abort_edges > 0) ? abort_edges : 8) begin
        @(negedge CPU_CLK);
        if (!DTACK_n) lows++;
        if (DATA_OE || RAM_CS_n != 2'b11) sels++;
      end
      check("no_dtack", lows, 0);
      if (!resp) check("no_select", sels, 0);
    end else begin
      got = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge CPU_CLK);
        if (ram && i == 0) check("cs_edge1", int'(RAM_CS_n), int'(ds));
        if (!DTACK_n) begin
          got = 1;
          break;
        end
      end
      check("dtack_seen", int'(got), 1);
      if (rst_in_ack) begin
        #1 RESET = 1'b1;
        #1 check_reset_outputs();
        @(negedge CPU_CLK);
        RESET = 1'b0;
        CPU_AS_n = 1'b1;
        m_st = 0;
        m_base = 8'h00;
        return;
      end
      repeat ($urandom_range(0, 2)) @(negedge CPU_CLK);
    end
    CPU_AS_n = 1'b1;
    UDS_n = 1'b1;
    LDS_n = 1'b1;
    @(negedge CPU_CLK);
    check("idle_dtack", int'(DTACK_n), 1);
    check("idle_oe", int'(DATA_OE), 0);
    check("idle_cs", int'(RAM_CS_n), 3);
    if (resp && abort_edges == 0 && ac && !rw) begin
      if (a[15:0] == 16'h004A) m_base[3:0] = din;
      if (a[15:0] == 16'h0048) begin
        m_base[7:4] = din;
        m_st = 1;
      end
      if (a[15:0] == 16'h004C) m_st = 2;
    end
    check("cfgout", int'(CFGOUT_n), (m_st == 0) ? 1 : 0);
  endtask

  // Monitor: pops one expectation on each DTACK assertion and holds it while DTACK is low.
  initial begin
    exp_t cur;
    bit in_ack;
    in_ack = 0;
    cur.oe = 0;
    forever begin
      @(negedge CPU_CLK);
      if (RESET) begin
        in_ack = 0;
      end else if (!DTACK_n) begin
        if (!in_ack) begin
          in_ack = 1;
          if (expq.size() == 0) begin
            check("unexpected_dtack", int'(DTACK_n), 1);
            cur.oe = 0;
          end else begin
            cur = expq.pop_front();
            check("latency", edge_cnt - cur.start, cur.lat);
            check("ack_cs", int'(RAM_CS_n), int'(cur.cs));
            check("ack_oe", int'(DATA_OE), int'(cur.oe));
            if (cur.oe) check("ack_data", int'(DATA_OUT), int'(cur.dout));
          end
        end else begin
          check("oe_held", int'(DATA_OE), int'(cur.oe));
        end
      end else begin
        in_ack = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  logic [23:0] ra;
  logic [3:0]  rn;
  logic [1:0]  rds;
  logic [7:0]  offs[4];

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = 4'hF;
    rom[0] = 4'hE;
    rom[1] = 4'h6;
    rom[2] = ~PID[7:4];
    rom[3] = ~PID[3:0];
    rom[4] = ~4'h8;
    for (int i = 0; i < 4; i++) rom[8 + i] = ~MANUF[15 - 4 * i -: 4];
    for (int i = 0; i < 8; i++) rom[12 + i] = ~SER[31 - 4 * i -: 4];
    offs[0] = 8'h40; offs[1] = 8'h44; offs[2] = 8'h4E; offs[3] = 8'h00;

    do_reset();
    bus(24'hE80000, 1, 2'b00, 4'h0, 0, 0);
    bus(24'hE80002, 1, 2'b00, 4'h0, 0, 0);
    bus(24'hE80010, 1, 2'b00, 4'h0, 0, 0);
    repeat (24) begin
      ra = {8'hE8, ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00, 7'($urandom), 1'b0};
      bus(ra, 1, 2'b00, 4'h0, 0, 0);
    end
    CFGIN_n = 1'b1;
    bus(24'hE80000, 1, 2'b00, 4'h0, 0, 0);
    CFGIN_n = 1'b0;
    bus(24'hE80048, 0, 2'b00, 4'h2, 1, 0);  // aborted config write
    repeat (4) bus({16'hE800, offs[$urandom_range(0, 3)]}, 0, 2'b00, 4'($urandom), 0, 0);
    bus(24'hE8004A, 0, 2'b00, 4'h0, 0, 0);
    bus(24'hE80048, 0, 2'b00, 4'h2, 0, 0);
    bus(24'h200000, 1, 2'b00, 4'h0, 0, 0);
    bus(24'hE80000, 1, 2'b00, 4'h0, 0, 0);
    repeat (25) begin
      ra  = $urandom_range(0, 1) ? {3'b001, 21'($urandom)} : 24'($urandom);
      rds = 2'($urandom_range(0, 2));
      bus(ra, 1'($urandom), rds, 4'($urandom), 0, 0);
    end
    bus(24'h200100, 1, 2'b00, 4'h0, RAM_WAIT + 1, 0);  // abort on the last ACCESS edge

    do_reset();
    bus(24'hE8004A, 0, 2'b00, 4'h5, 0, 0);
    bus(24'hE80048, 0, 2'b00, 4'h6, 0, 1);
    bus(24'hE80002, 1, 2'b00, 4'h0, 0, 0);
    rn = 4'($urandom);
    bus(24'hE80048, 0, 2'b00, rn, 0, 0);  // 48 before 4A: low base nibble stays 0
    repeat (20) begin
      ra  = $urandom_range(0, 1) ? {rn[3:1], 21'($urandom)} : 24'($urandom);
      rds = 2'($urandom_range(0, 2));
      bus(ra, 1'($urandom), rds, 4'($urandom), 0, 0);
    end

    do_reset();
    bus(24'hE8004C, 0, 2'b00, 4'h0, 0, 0);
    bus(24'hE80000, 1, 2'b00, 4'h0, 0, 0);
    repeat (10) bus(24'($urandom), 1'($urandom), 2'b00, 4'($urandom), 0, 0);

    repeat (3) @(negedge CPU_CLK);
    check("queue_drained", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
